// File: rtl/register_file_mp_pkg.sv
// Shared types and defaults for the multi-port register file: clear-FSM states,
// default geometry and the hardwired zero register index.
package register_file_mp_pkg;

    localparam int unsigned RF_DEF_PORTS = 2;
    localparam int unsigned RF_DEF_ADDR  = 5;
    localparam int unsigned RF_DEF_WIDTH = 32;
    localparam int unsigned RF_ZERO_REG  = 0;

    typedef enum logic [0:0] {
        RF_IDLE,
        RF_CLEAR
    } rf_clr_state_e;

    typedef logic [RF_DEF_ADDR-1:0]  rf_addr_t;
    typedef logic [RF_DEF_WIDTH-1:0] rf_data_t;

endpackage

// File: rtl/register_file_mp_if.sv
// Issue/writeback-side bundle of the register file: write ports, read ports,
// scoreboard mark and bulk-clear handshake.
interface register_file_mp_if
    import register_file_mp_pkg::*;
#(
    parameter int unsigned RPORTS = RF_DEF_PORTS,
    parameter int unsigned WPORTS = RF_DEF_PORTS,
    parameter int unsigned ADDR   = RF_DEF_ADDR,
    parameter int unsigned WIDTH  = RF_DEF_WIDTH
);
    logic [WPORTS-1:0]            we;
    logic [WPORTS-1:0][ADDR-1:0]  waddr;
    logic [WPORTS-1:0][WIDTH-1:0] din;
    logic [RPORTS-1:0][ADDR-1:0]  raddr;
    logic [RPORTS-1:0][WIDTH-1:0] dout;
    logic [RPORTS-1:0]            rpend;
    logic                         mark;
    logic [ADDR-1:0]              mark_addr;
    logic                         clr_req;
    logic                         clr_busy;
    logic                         clr_done;

    modport master (
        output we, waddr, din, raddr, mark, mark_addr, clr_req,
        input  dout, rpend, clr_busy, clr_done
    );

    modport slave (
        input  we, waddr, din, raddr, mark, mark_addr, clr_req,
        output dout, rpend, clr_busy, clr_done
    );

endinterface

// File: rtl/register_file_mp_clear_seq.sv
// Bulk-clear sequencer: walks addresses 1..2**ADDR-1, one per cycle, after a clear request.
module register_file_mp_clear_seq
    import register_file_mp_pkg::*;
#(
    parameter int unsigned ADDR = RF_DEF_ADDR
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr_req,
    output logic            clr_en,
    output logic [ADDR-1:0] clr_addr,
    output logic            clr_busy,
    output logic            clr_done
);
    localparam logic [ADDR-1:0] First  = ADDR'(1);
    localparam logic [ADDR-1:0] Last   = '1;
    localparam logic [ADDR-1:0] Penult = Last - First;

    rf_clr_state_e   state_q;
    logic [ADDR-1:0] cnt_q;
    logic            busy_q;
    logic            done_q;

    // Register 0 is never stored, so the walk starts at 1 and ends on a terminal compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                RF_IDLE: begin
                    if (clr_req) begin
                        state_q <= RF_CLEAR;
                        cnt_q   <= First;
                        busy_q  <= 1'b1;
                        done_q  <= (First == Last);
                    end
                end
                RF_CLEAR: begin
                    if (cnt_q == Last) begin
                        state_q <= RF_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q + First;
                        done_q <= (cnt_q == Penult);
                    end
                end
                default: begin
                    state_q <= RF_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en   = busy_q;
    assign clr_addr = cnt_q;
    assign clr_busy = busy_q;
    assign clr_done = done_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port GPR file with write-to-read bypass, pending scoreboard and bulk clear.
// Register 0 reads as zero and is never pending.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int unsigned RPORTS = RF_DEF_PORTS,
    parameter int unsigned WPORTS = RF_DEF_PORTS,
    parameter int unsigned ADDR   = RF_DEF_ADDR,
    parameter int unsigned WIDTH  = RF_DEF_WIDTH,
    parameter int unsigned BYPASS = 1
) (
    input logic               clk,
    input logic               reset_n,
    register_file_mp_if.slave bus
);
    localparam int unsigned     Depth = 2 ** ADDR;
    localparam logic [ADDR-1:0] Zero  = ADDR'(RF_ZERO_REG);

    logic [Depth-1:0][WIDTH-1:0]  mem_q, mem_d;
    logic [Depth-1:0]             pend_q, pend_d;
    logic                         clr_en;
    logic [ADDR-1:0]              clr_addr;
    logic [RPORTS-1:0][WIDTH-1:0] dout;
    logic [RPORTS-1:0]            rpend;

    register_file_mp_clear_seq #(
        .ADDR (ADDR)
    ) u_clear_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_req  (bus.clr_req),
        .clr_en   (clr_en),
        .clr_addr (clr_addr),
        .clr_busy (bus.clr_busy),
        .clr_done (bus.clr_done)
    );

    // Later ports overwrite earlier ones, so the highest-index port wins a conflict;
    // mark is applied after the writes so it beats a same-cycle write.
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (clr_en) begin
            mem_d[clr_addr]  = '0;
            pend_d[clr_addr] = 1'b0;
        end else begin
            for (int j = 0; j < int'(WPORTS); j++) begin
                if (bus.we[j] && bus.waddr[j] != Zero) begin
                    mem_d[bus.waddr[j]]  = bus.din[j];
                    pend_d[bus.waddr[j]] = 1'b0;
                end
            end
            if (bus.mark && bus.mark_addr != Zero) begin
                pend_d[bus.mark_addr] = 1'b1;
            end
        end
        mem_d[RF_ZERO_REG]  = '0;
        pend_d[RF_ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q  <= '0;
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    // Forwarding is suppressed while clearing: those writes are dropped, so they must not leak.
    always_comb begin
        dout  = '0;
        rpend = '0;
        for (int i = 0; i < int'(RPORTS); i++) begin
            dout[i]  = mem_q[bus.raddr[i]];
            rpend[i] = pend_q[bus.raddr[i]];
            if (BYPASS != 0 && !clr_en) begin
                for (int j = 0; j < int'(WPORTS); j++) begin
                    if (bus.we[j] && bus.waddr[j] == bus.raddr[i]) begin
                        dout[i]  = bus.din[j];
                        rpend[i] = 1'b0;
                    end
                end
            end
            if (bus.raddr[i] == Zero) begin
                dout[i]  = '0;
                rpend[i] = 1'b0;
            end
        end
    end

    assign bus.dout  = dout;
    assign bus.rpend = rpend;

endmodule
